// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage and a 128-bit block memory.
// Hits complete in the request cycle; misses hold proc_stall high through writeback/fill plus one compare cycle.
module dcache_direct_wb #(
   parameter int NUM_BLOCKS = 8,
   parameter int INDEX_W    = 3,
   parameter int TAG_W      = 25
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       proc_read,
   input  logic                       proc_write,
   input  logic [29:0]                proc_addr,
   input  logic [31:0]                proc_wdata,
   output logic                       proc_stall,
   output logic [31:0]                proc_rdata,
   output logic                       mem_read,
   output logic                       mem_write,
   output logic [TAG_W+INDEX_W-1:0]   mem_addr,
   output logic [127:0]               mem_wdata,
   input  logic [127:0]               mem_rdata,
   input  logic                       mem_ready
);

   typedef enum logic [1:0] {
      S_COMPARE   = 2'd0,
      S_WRITEBACK = 2'd1,
      S_ALLOCATE  = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;

   logic [NUM_BLOCKS-1:0]      r_valid;
   logic [NUM_BLOCKS-1:0]      r_dirty;
   logic [TAG_W-1:0]           r_tag  [NUM_BLOCKS];
   logic [127:0]               r_data [NUM_BLOCKS];

   logic                       r_mem_read;
   logic                       r_mem_write;
   logic [TAG_W+INDEX_W-1:0]   r_mem_addr;
   logic [127:0]               r_mem_wdata;

   logic                       w_mem_read_nxt;
   logic                       w_mem_write_nxt;
   logic [TAG_W+INDEX_W-1:0]   w_mem_addr_nxt;
   logic [127:0]               w_mem_wdata_nxt;

   logic [INDEX_W-1:0]         w_index;
   logic [1:0]                 w_offset;
   logic [TAG_W-1:0]           w_tag;
   logic                       w_req;
   logic                       w_hit;
   logic                       w_victim_dirty;
   logic [127:0]               w_line;
   logic [127:0]               w_line_merged;
   logic                       w_wr_hit;
   logic                       w_fill;

   assign w_index        = proc_addr[INDEX_W+1:2];
   assign w_offset       = proc_addr[1:0];
   assign w_tag          = proc_addr[29:INDEX_W+2];
   assign w_req          = proc_read | proc_write;
   assign w_line         = r_data[w_index];
   assign w_hit          = r_valid[w_index] & (r_tag[w_index] == w_tag);
   assign w_victim_dirty = r_valid[w_index] & r_dirty[w_index];

   // Reads always see the stored word, so a combined read+write returns the pre-write value.
   assign proc_rdata = w_line[{w_offset, 5'd0} +: 32];

   always_comb begin
      w_line_merged = w_line;
      w_line_merged[{w_offset, 5'd0} +: 32] = proc_wdata;
   end

   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_COMPARE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COMPARE: begin
            if (w_req && !w_hit) begin
               w_state_nxt = w_victim_dirty ? S_WRITEBACK : S_ALLOCATE;
            end
         end
         S_WRITEBACK: begin
            if (mem_ready) w_state_nxt = S_ALLOCATE;
         end
         S_ALLOCATE: begin
            if (mem_ready) w_state_nxt = S_COMPARE;
         end
         default: w_state_nxt = S_COMPARE;
      endcase
   end

   // Output logic: stall, array update strobes and next values of the registered memory request
   always_comb begin
      proc_stall      = w_req & ~((r_state == S_COMPARE) & w_hit);
      w_wr_hit        = 1'b0;
      w_fill          = 1'b0;
      w_mem_read_nxt  = r_mem_read;
      w_mem_write_nxt = r_mem_write;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      case (r_state)
         S_COMPARE: begin
            if (w_req && !w_hit) begin
               if (w_victim_dirty) begin
                  w_mem_write_nxt = 1'b1;
                  w_mem_addr_nxt  = {r_tag[w_index], w_index};
                  w_mem_wdata_nxt = w_line;
               end else begin
                  w_mem_read_nxt  = 1'b1;
                  w_mem_addr_nxt  = {w_tag, w_index};
               end
            end else if (proc_write && w_hit) begin
               w_wr_hit = 1'b1;
            end
         end
         S_WRITEBACK: begin
            if (mem_ready) begin
               w_mem_write_nxt = 1'b0;
               w_mem_read_nxt  = 1'b1;
               w_mem_addr_nxt  = {w_tag, w_index};
            end
         end
         S_ALLOCATE: begin
            if (mem_ready) begin
               w_mem_read_nxt = 1'b0;
               w_fill         = 1'b1;
            end
         end
         default: begin
            w_mem_read_nxt  = 1'b0;
            w_mem_write_nxt = 1'b0;
         end
      endcase
   end

   // Memory request registers drop asynchronously on reset, abandoning any transfer in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_read  <= w_mem_read_nxt;
         r_mem_write <= w_mem_write_nxt;
         r_mem_addr  <= w_mem_addr_nxt;
         r_mem_wdata <= w_mem_wdata_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
      end else if (w_fill) begin
         r_valid[w_index] <= 1'b1;
         r_dirty[w_index] <= 1'b0;
      end else if (w_wr_hit) begin
         r_dirty[w_index] <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid gates every use of them.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[w_index]  <= w_tag;
         r_data[w_index] <= mem_rdata;
      end else if (w_wr_hit) begin
         r_data[w_index] <= w_line_merged;
      end
   end

endmodule
